// File: rtl/sccomp_ahb_resp_mux_pkg.sv
// Shared AHB-Lite definitions for the sccomp bus fabric.
// FSM states, HTRANS codes, slave map and indices.
package sccomp_ahb_resp_mux_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SLV  = 2'd1,
    ST_ERR1 = 2'd2,
    ST_ERR2 = 2'd3
  } state_t;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_BUSY   = 2'b01;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ    = 2'b11;

  localparam logic [31:0] RRAM_BASE = 32'h0000_0000;
  localparam logic [31:0] RRAM_MASK = 32'hFFFF_F000;
  localparam logic [31:0] RAM_BASE  = 32'h1000_0000;
  localparam logic [31:0] RAM_MASK  = 32'hFFFF_0000;
  localparam logic [31:0] GPIO_BASE = 32'h2000_0000;
  localparam logic [31:0] GPIO_MASK = 32'hFFFF_FF00;

  localparam int SLV_RRAM = 0;
  localparam int SLV_RAM  = 1;
  localparam int SLV_GPIO = 2;

  function automatic logic htrans_active(
    input logic [1:0] t
  );
    return (t == HTRANS_NONSEQ) ||
           (t == HTRANS_SEQ);
  endfunction

endpackage

// File: rtl/sccomp_ahb_default_slave.sv
// Default slave: two-cycle ERROR sequencer and
// data-phase watchdog for the response mux.
module sccomp_ahb_default_slave
  import sccomp_ahb_resp_mux_pkg::*;
#(
  parameter int TIMEOUT = 256,
  parameter int TW      = 9
) (
  input  logic   clk,
  input  logic   rst,
  input  state_t state,
  input  logic   slv_rdy,
  input  logic   accept,
  output logic   done,
  output logic   resp,
  output logic   fire,
  output logic   timeout_err
);

  localparam logic [TW-1:0] LIMIT = TW'(TIMEOUT - 1);

  logic [TW-1:0] cnt;
  logic          stall;

  assign stall = (state == ST_SLV) && !slv_rdy;

  // Fires on the stalled cycle that brings the count to TIMEOUT.
  assign fire = (TIMEOUT != 0) && stall &&
                (cnt == LIMIT);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (accept) begin
      cnt <= '0;
    end else if (stall && (cnt != '1)) begin
      cnt <= cnt + TW'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      timeout_err <= 1'b0;
    end else begin
      timeout_err <= fire;
    end
  end

  assign done = (state == ST_ERR2);
  assign resp = (state == ST_ERR1) ||
                (state == ST_ERR2);

endmodule

// File: rtl/sccomp_ahb_resp_mux.sv
// AHB-Lite return-path mux: routes the selected slave's
// data-phase response to the single master.
module sccomp_ahb_resp_mux
  import sccomp_ahb_resp_mux_pkg::*;
#(
  parameter int NSLV    = 3,
  parameter int DW      = 32,
  parameter int TIMEOUT = 256,
  parameter int TW      = 9
) (
  input  logic              HCLK,
  input  logic              HRESET,
  input  logic [NSLV-1:0]   HSEL,
  input  logic [1:0]        HTRANS,
  input  logic [NSLV*DW-1:0] HRDATA_S,
  input  logic [NSLV-1:0]   HREADYOUT_S,
  input  logic [NSLV-1:0]   HRESP_S,
  output logic [DW-1:0]     HRDATA,
  output logic              HREADY,
  output logic              HRESP,
  output logic              TIMEOUT_ERR
);

  localparam int SW = $clog2(NSLV + 1);
  localparam logic [SW-1:0] SEL_NONE = SW'(NSLV);

  state_t        state;
  state_t        state_nxt;
  logic [SW-1:0] sel_q;
  logic [SW-1:0] sel_d;
  logic          accept;
  logic          active;
  logic          hit;
  logic          slv_rdy;
  logic          slv_rsp;
  logic [DW-1:0] slv_data;
  logic          dflt_done;
  logic          dflt_rsp;
  logic          fire;

  assign accept = HREADY;
  assign active = htrans_active(HTRANS);
  assign hit    = (sel_d != SEL_NONE);

  // Lowest set bit wins on a faulty multi-hot HSEL.
  always_comb begin
    sel_d = SEL_NONE;
    for (int k = NSLV - 1; k >= 0; k--) begin
      if (HSEL[k]) begin
        sel_d = SW'(k);
      end
    end
  end

  always_comb begin
    slv_rdy  = 1'b0;
    slv_rsp  = 1'b0;
    slv_data = '0;
    for (int k = 0; k < NSLV; k++) begin
      if (sel_q == SW'(k)) begin
        slv_rdy  = HREADYOUT_S[k];
        slv_rsp  = HRESP_S[k];
        slv_data = HRDATA_S[k*DW +: DW];
      end
    end
  end

  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      sel_q <= SEL_NONE;
    end else if (accept) begin
      sel_q <= sel_d;
    end
  end

  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    unique case (1'b1)
      (state == ST_ERR1): state_nxt = ST_ERR2;
      fire:               state_nxt = ST_ERR1;
      accept: begin
        if (!active) begin
          state_nxt = ST_IDLE;
        end else if (hit) begin
          state_nxt = ST_SLV;
        end else begin
          state_nxt = ST_ERR1;
        end
      end
      default: ;
    endcase
  end

  always_comb begin
    HREADY = 1'b1;
    HRESP  = 1'b0;
    HRDATA = '0;
    unique case (state)
      ST_SLV: begin
        HREADY = slv_rdy;
        HRESP  = slv_rsp;
        HRDATA = slv_data;
      end
      ST_ERR1, ST_ERR2: begin
        HREADY = dflt_done;
        HRESP  = dflt_rsp;
      end
      default: ;
    endcase
  end

  sccomp_ahb_default_slave #(
    .TIMEOUT (TIMEOUT),
    .TW      (TW)
  ) u_dflt (
    .clk         (HCLK),
    .rst         (HRESET),
    .state       (state),
    .slv_rdy     (slv_rdy),
    .accept      (accept),
    .done        (dflt_done),
    .resp        (dflt_rsp),
    .fire        (fire),
    .timeout_err (TIMEOUT_ERR)
  );

endmodule
